// File: rtl/hazard_fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl_if
// Description : Stage-side signal bundle for the ID hazard/forwarding
//               controller. Register IDs and control bits go to the
//               controller. Forward selects and stall/flush controls come back.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_ctrl_if;
    // ID stage
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       useAD;
    logic       useBD;
    logic       hiloReadD;
    // EX stage
    logic [4:0] WriteRegE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic       hiloMoveE;
    logic       mdStartE;
    logic       mdIsDivE;
    // MEM stage
    logic [4:0] WriteRegM;
    logic       RegWriteM;
    logic [1:0] loadTypeM;
    logic       hiloMoveM;
    // controller results
    logic [2:0] ForwardAD;
    logic [2:0] ForwardBD;
    logic       stallF;
    logic       stallD;
    logic       flushE;
    logic       mdBusy;

    // Pipeline side: drives the stage information and consumes the controls
    modport master (
        output rsD, rtD, useAD, useBD, hiloReadD,
        output WriteRegE, RegWriteE, MemtoRegE, hiloMoveE, mdStartE, mdIsDivE,
        output WriteRegM, RegWriteM, loadTypeM, hiloMoveM,
        input  ForwardAD, ForwardBD, stallF, stallD, flushE, mdBusy
    );

    // Controller side
    modport slave (
        input  rsD, rtD, useAD, useBD, hiloReadD,
        input  WriteRegE, RegWriteE, MemtoRegE, hiloMoveE, mdStartE, mdIsDivE,
        input  WriteRegM, RegWriteM, loadTypeM, hiloMoveM,
        output ForwardAD, ForwardBD, stallF, stallD, flushE, mdBusy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : ID-stage forwarding select generation, load-use and HI/LO
//               busy stall detection, and the mult/div occupancy countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6    // must be wide enough to hold DIV_CYCLES
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_fwd_ctrl_if.slave   bus
);

    // Forward select encodings seen by the ID operand muxes
    localparam logic [2:0] C_FWD_RF    = 3'd0;
    localparam logic [2:0] C_FWD_ALUE  = 3'd1;
    localparam logic [2:0] C_FWD_ALUM  = 3'd2;
    localparam logic [2:0] C_FWD_WORDM = 3'd3;
    localparam logic [2:0] C_FWD_HALFM = 3'd4;
    localparam logic [2:0] C_FWD_BYTEM = 3'd5;
    localparam logic [2:0] C_FWD_HILOE = 3'd6;
    localparam logic [2:0] C_FWD_HILOM = 3'd7;

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       fwd_a_d;
    logic [2:0]       fwd_b_d;
    logic             load_use_a_d;
    logic             load_use_b_d;
    logic             stall_d;

    // Returns {load_use, select} for one source operand. An EX producer beats
    // a MEM producer because it is the younger write. $zero never matches.
    function automatic logic [3:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic [4:0] wr_e,
        input logic       we_e,
        input logic       load_e,
        input logic       hilo_e,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [1:0] ltype_m,
        input logic       hilo_m
    );
        logic [3:0] r;
        r = {1'b0, C_FWD_RF};
        if (use_src && (src != 5'd0)) begin
            if (we_e && (wr_e == src)) begin
                if (hilo_e)      r = {1'b0, C_FWD_HILOE};
                else if (load_e) r = {1'b1, C_FWD_RF};
                else             r = {1'b0, C_FWD_ALUE};
            end else if (we_m && (wr_m == src)) begin
                if (hilo_m) begin
                    r = {1'b0, C_FWD_HILOM};
                end else begin
                    case (ltype_m)
                        2'd1:    r = {1'b0, C_FWD_WORDM};
                        2'd2:    r = {1'b0, C_FWD_HALFM};
                        2'd3:    r = {1'b0, C_FWD_BYTEM};
                        default: r = {1'b0, C_FWD_ALUM};
                    endcase
                end
            end
        end
        return r;
    endfunction

    // Per-operand forward selects, load-use detection and the combined stall
    always_comb begin
        {load_use_a_d, fwd_a_d} = fwd_sel(bus.rsD, bus.useAD,
            bus.WriteRegE, bus.RegWriteE, bus.MemtoRegE, bus.hiloMoveE,
            bus.WriteRegM, bus.RegWriteM, bus.loadTypeM, bus.hiloMoveM);
        {load_use_b_d, fwd_b_d} = fwd_sel(bus.rtD, bus.useBD,
            bus.WriteRegE, bus.RegWriteE, bus.MemtoRegE, bus.hiloMoveE,
            bus.WriteRegM, bus.RegWriteM, bus.loadTypeM, bus.hiloMoveM);
        // the mdStartE term catches a HI/LO reader directly behind the issue
        stall_d = load_use_a_d | load_use_b_d |
                  (bus.hiloReadD & ((cnt_q != '0) | bus.mdStartE));
    end

    // Busy countdown next state: a new issue reloads, else count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (bus.mdStartE)       cnt_d = bus.mdIsDivE ? C_DIV_LOAD : C_MULT_LOAD;
        else if (cnt_q != '0)   cnt_d = cnt_q - C_CNT_ONE;
    end

    // Busy counter register; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.ForwardAD = fwd_a_d;
    assign bus.ForwardBD = fwd_b_d;
    assign bus.stallF    = stall_d;
    assign bus.stallD    = stall_d;
    assign bus.flushE    = stall_d;
    assign bus.mdBusy    = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Directed self-checking bench for hazard_fwd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_fwd_ctrl_if bus ();

    hazard_fwd_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.rsD = 5'd0;       bus.rtD = 5'd0;
        bus.useAD = 1'b0;     bus.useBD = 1'b0;     bus.hiloReadD = 1'b0;
        bus.WriteRegE = 5'd0; bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0;
        bus.hiloMoveE = 1'b0; bus.mdStartE = 1'b0;  bus.mdIsDivE = 1'b0;
        bus.WriteRegM = 5'd0; bus.RegWriteM = 1'b0; bus.loadTypeM = 2'd0;
        bus.hiloMoveM = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are driven there
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Stall outputs must agree and match the expectation
    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".stallF"}, {7'd0, bus.stallF}, {7'd0, exp});
        chk({tag, ".stallD"}, {7'd0, bus.stallD}, {7'd0, exp});
        chk({tag, ".flushE"}, {7'd0, bus.flushE}, {7'd0, exp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("reset.mdBusy", {7'd0, bus.mdBusy}, 8'd0);
        chk("reset.fwdA",   {5'd0, bus.ForwardAD}, 8'd0);
        chk_stall("reset", 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // EX ALU producer
        bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd8; bus.rsD = 5'd8; bus.useAD = 1'b1;
        #1;
        chk("exalu.fwdA", {5'd0, bus.ForwardAD}, 8'd1);
        chk_stall("exalu", 1'b0);
        // MEM also writes r8: EX stays in charge
        bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd8;
        #1;
        chk("expri.fwdA", {5'd0, bus.ForwardAD}, 8'd1);
        // EX drops out: MEM ALU result
        bus.RegWriteE = 1'b0;
        #1;
        chk("memalu.fwdA", {5'd0, bus.ForwardAD}, 8'd2);
        // operand not used -> register file
        bus.useAD = 1'b0;
        #1;
        chk("nouse.fwdA", {5'd0, bus.ForwardAD}, 8'd0);

        // MEM loads on operand B
        clear_inputs();
        bus.WriteRegM = 5'd9; bus.RegWriteM = 1'b1; bus.rtD = 5'd9; bus.useBD = 1'b1;
        bus.loadTypeM = 2'd1; #1; chk("memword.fwdB", {5'd0, bus.ForwardBD}, 8'd3);
        bus.loadTypeM = 2'd2; #1; chk("memhalf.fwdB", {5'd0, bus.ForwardBD}, 8'd4);
        bus.loadTypeM = 2'd3; #1; chk("membyte.fwdB", {5'd0, bus.ForwardBD}, 8'd5);
        bus.hiloMoveM = 1'b1; #1; chk("memhilo.fwdB", {5'd0, bus.ForwardBD}, 8'd7);
        bus.hiloMoveE = 1'b1; bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd9;
        #1;
        chk("exhilo.fwdB", {5'd0, bus.ForwardBD}, 8'd6);
        chk("exhilo.fwdA", {5'd0, bus.ForwardAD}, 8'd0);
        chk_stall("exhilo", 1'b0);

        // Load-use on operand A
        next_cycle();
        clear_inputs();
        bus.MemtoRegE = 1'b1; bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd4;
        bus.rsD = 5'd4; bus.useAD = 1'b1;
        #1;
        chk_stall("loaduse", 1'b1);
        chk("loaduse.fwdA", {5'd0, bus.ForwardAD}, 8'd0);
        next_cycle();
        clear_inputs();
        bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd4; bus.loadTypeM = 2'd1;
        bus.rsD = 5'd4; bus.useAD = 1'b1;
        #1;
        chk_stall("loadnext", 1'b0);
        chk("loadnext.fwdA", {5'd0, bus.ForwardAD}, 8'd3);
        // Load-use on operand B only
        clear_inputs();
        bus.MemtoRegE = 1'b1; bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd12;
        bus.rtD = 5'd12; bus.useBD = 1'b1; bus.rsD = 5'd3; bus.useAD = 1'b1;
        #1;
        chk_stall("loaduseB", 1'b1);

        // $zero is never forwarded nor stalled on
        clear_inputs();
        bus.WriteRegE = 5'd0; bus.RegWriteE = 1'b1; bus.MemtoRegE = 1'b1;
        bus.rsD = 5'd0; bus.useAD = 1'b1;
        bus.RegWriteM = 1'b1; bus.WriteRegM = 5'd0; bus.rtD = 5'd0; bus.useBD = 1'b1;
        #1;
        chk("zero.fwdA", {5'd0, bus.ForwardAD}, 8'd0);
        chk("zero.fwdB", {5'd0, bus.ForwardBD}, 8'd0);
        chk_stall("zero", 1'b0);

        // Divide busy window with a HI/LO reader held in ID
        next_cycle();
        clear_inputs();
        bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b1; bus.hiloReadD = 1'b1;
        #1;
        chk("div.issue.stall", {7'd0, bus.stallD}, 8'd1);
        chk("div.issue.busy",  {7'd0, bus.mdBusy}, 8'd0);
        next_cycle();
        bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("div.c%0d.busy", i + 1),  {7'd0, bus.mdBusy}, 8'd1);
            chk($sformatf("div.c%0d.stall", i + 1), {7'd0, bus.stallF}, 8'd1);
            next_cycle();
        end
        #1;
        chk("div.c33.busy", {7'd0, bus.mdBusy}, 8'd0);
        chk_stall("div.c33", 1'b0);

        // Multiply busy window
        next_cycle();
        bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b0;
        #1;
        chk("mul.issue.stall", {7'd0, bus.stallD}, 8'd1);
        next_cycle();
        bus.mdStartE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mul.c%0d.busy", i + 1), {7'd0, bus.mdBusy}, 8'd1);
            next_cycle();
        end
        #1;
        chk("mul.c5.busy", {7'd0, bus.mdBusy}, 8'd0);
        chk_stall("mul.c5", 1'b0);

        // A new issue reloads a running count (mult then div overrides)
        next_cycle();
        bus.mdStartE = 1'b1; bus.mdIsDivE = 1'b0; bus.hiloReadD = 1'b0;
        next_cycle();
        next_cycle();
        bus.mdIsDivE = 1'b1;
        next_cycle();
        bus.mdStartE = 1'b0; bus.mdIsDivE = 1'b0;
        for (int i = 0; i < 10; i++) next_cycle();
        #1;
        chk("reload.busy", {7'd0, bus.mdBusy}, 8'd1);
        chk_stall("reload.noread", 1'b0);

        // Asynchronous reset mid-divide, between clock edges
        bus.hiloReadD = 1'b1;
        #1;
        chk("midop.stall", {7'd0, bus.stallF}, 8'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.busy", {7'd0, bus.mdBusy}, 8'd0);
        chk_stall("arst", 1'b0);
        next_cycle();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk($sformatf("postrst.c%0d.busy", i), {7'd0, bus.mdBusy}, 8'd0);
        end
        chk_stall("postrst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
